// File: rtl/absmax_quantizer.sv
// Block absmax quantizer: buffers BLOCK_BEATS input beats, tracks the block's largest
// magnitude, then replays every beat scaled into signed QUANTIZATION_WIDTH values.
module absmax_quantizer #(
  parameter int IN_WIDTH           = 16,
  parameter int IN_SIZE            = 4,
  parameter int IN_PARALLELISM     = 1,
  parameter int BLOCK_BEATS        = 4,
  parameter int QUANTIZATION_WIDTH = 8,
  parameter int MAX_NUM_WIDTH      = IN_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic signed [IN_WIDTH-1:0]           data_in [IN_SIZE*IN_PARALLELISM],
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  output logic signed [QUANTIZATION_WIDTH-1:0] data_out [IN_SIZE*IN_PARALLELISM],
  output logic [MAX_NUM_WIDTH-1:0]             max_num,
  output logic                                 data_out_last,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready
);

  localparam int N      = IN_SIZE * IN_PARALLELISM;
  localparam int CNT_W  = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
  localparam int QMAX   = (1 << (QUANTIZATION_WIDTH - 1)) - 1;
  localparam int PROD_W = IN_WIDTH + QUANTIZATION_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BEATS - 1);

  typedef enum logic {
    COLLECT,
    EMIT
  } state_t;

  state_t                     state_q;
  logic [CNT_W-1:0]           wrCnt_q;
  logic [CNT_W-1:0]           rdCnt_q;
  logic [CNT_W-1:0]           wrCnt_d;
  logic [CNT_W-1:0]           rdCnt_d;
  logic [MAX_NUM_WIDTH-1:0]   max_q;
  logic [MAX_NUM_WIDTH-1:0]   max_d;
  logic                       inReady_q;
  logic                       outValid_q;
  logic                       outLast_q;
  logic                       inAccept;
  logic                       outAccept;
  logic [MAX_NUM_WIDTH-1:0]   absIn [N];
  logic [MAX_NUM_WIDTH-1:0]   beatMax;
  logic [IN_WIDTH-1:0]        buffer_q [BLOCK_BEATS][N];

  assign data_in_ready  = inReady_q;
  assign data_out_valid = outValid_q;
  assign data_out_last  = outLast_q;
  assign max_num        = max_q;

  assign inAccept  = data_in_valid & inReady_q & (state_q == COLLECT);
  assign outAccept = data_out_ready & outValid_q & (state_q == EMIT);
  assign wrCnt_d   = wrCnt_q + CNT_W'(1);
  assign rdCnt_d   = rdCnt_q + CNT_W'(1);

  // Magnitudes are unsigned, so the most negative input maps to 2^(IN_WIDTH-1) exactly.
  for (genvar g = 0; g < N; g++) begin : gAbs
    logic [IN_WIDTH-1:0] raw;
    assign raw      = data_in[g];
    assign absIn[g] = MAX_NUM_WIDTH'(raw[IN_WIDTH-1] ? (~raw) + IN_WIDTH'(1) : raw);
  end

  always_comb begin
    beatMax = '0;
    for (int i = 0; i < N; i++) begin
      if (absIn[i] > beatMax) beatMax = absIn[i];
    end
  end

  // The first beat of a block restarts the running max instead of folding in the old one.
  always_comb begin
    max_d = beatMax;
    if (wrCnt_q != '0 && max_q > beatMax) max_d = max_q;
  end

  always_ff @(posedge clk) begin
    if (inAccept) begin
      for (int i = 0; i < N; i++) buffer_q[wrCnt_q][i] <= data_in[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      wrCnt_q    <= '0;
      rdCnt_q    <= '0;
      max_q      <= '0;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          inReady_q <= 1'b1;
          if (inAccept) begin
            max_q <= max_d;
            if (wrCnt_q == LAST_IDX) begin
              state_q    <= EMIT;
              wrCnt_q    <= '0;
              rdCnt_q    <= '0;
              inReady_q  <= 1'b0;
              outValid_q <= 1'b1;
              outLast_q  <= (LAST_IDX == '0);
            end else begin
              wrCnt_q <= wrCnt_d;
            end
          end
        end
        EMIT: begin
          if (outAccept) begin
            if (rdCnt_q == LAST_IDX) begin
              state_q    <= COLLECT;
              rdCnt_q    <= '0;
              inReady_q  <= 1'b1;
              outValid_q <= 1'b0;
              outLast_q  <= 1'b0;
            end else begin
              rdCnt_q   <= rdCnt_d;
              outLast_q <= (rdCnt_d == LAST_IDX);
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  // Rounded scaling; since |x| <= max the quotient never exceeds QMAX.
  for (genvar g = 0; g < N; g++) begin : gQuant
    logic [IN_WIDTH-1:0]           elem;
    logic [IN_WIDTH-1:0]           elemMag;
    logic [PROD_W-1:0]             numer;
    logic [PROD_W-1:0]             divisor;
    logic [PROD_W-1:0]             quot;
    logic [QUANTIZATION_WIDTH-1:0] mag;
    assign elem    = buffer_q[rdCnt_q][g];
    assign elemMag = elem[IN_WIDTH-1] ? (~elem) + IN_WIDTH'(1) : elem;
    assign numer   = PROD_W'(elemMag) * PROD_W'(QMAX) + PROD_W'(max_q >> 1);
    assign divisor = (max_q == '0) ? PROD_W'(1) : PROD_W'(max_q);
    assign quot    = (max_q == '0) ? '0 : numer / divisor;
    assign mag     = QUANTIZATION_WIDTH'(quot);
    assign data_out[g] = elem[IN_WIDTH-1] ? (~mag) + QUANTIZATION_WIDTH'(1) : mag;
  end

endmodule

// File: tb/tb_absmax_quantizer.sv
// Directed bench for absmax_quantizer with two-beat blocks: table-driven blocks plus
// hand-written hold, reset and back-to-back sequences.
module tb_absmax_quantizer;

  logic              clk;
  logic              rst;
  logic signed [15:0] data_in [4];
  logic              data_in_valid;
  logic              data_in_ready;
  logic signed [7:0] data_out [4];
  logic [15:0]       max_num;
  logic              data_out_last;
  logic              data_out_valid;
  logic              data_out_ready;

  int checks;
  int failures;

  typedef struct {
    int in0[4];
    int in1[4];
    int expMax;
    int out0[4];
    int out1[4];
  } vec_t;

  vec_t vecs [6];

  absmax_quantizer #(
    .IN_WIDTH(16),
    .IN_SIZE(4),
    .IN_PARALLELISM(1),
    .BLOCK_BEATS(2),
    .QUANTIZATION_WIDTH(8),
    .MAX_NUM_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .data_out(data_out),
    .max_num(max_num),
    .data_out_last(data_out_last),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic fillVectors();
    vecs[0].in0 = '{100, -50, 25, 0};     vecs[0].in1 = '{200, -200, 1, 2};
    vecs[0].expMax = 200;
    vecs[0].out0 = '{64, -32, 16, 0};     vecs[0].out1 = '{127, -127, 1, 1};
    vecs[1].in0 = '{0, 0, 0, 0};          vecs[1].in1 = '{0, 0, 0, 0};
    vecs[1].expMax = 0;
    vecs[1].out0 = '{0, 0, 0, 0};         vecs[1].out1 = '{0, 0, 0, 0};
    vecs[2].in0 = '{-32768, 16384, 0, 0}; vecs[2].in1 = '{0, 0, 0, 0};
    vecs[2].expMax = 32768;
    vecs[2].out0 = '{-127, 64, 0, 0};     vecs[2].out1 = '{0, 0, 0, 0};
    vecs[3].in0 = '{10, 0, 0, 0};         vecs[3].in1 = '{0, 0, 0, 0};
    vecs[3].expMax = 10;
    vecs[3].out0 = '{127, 0, 0, 0};       vecs[3].out1 = '{0, 0, 0, 0};
    vecs[4].in0 = '{-3, 7, -7, 1};        vecs[4].in1 = '{2, 0, -1, 5};
    vecs[4].expMax = 7;
    vecs[4].out0 = '{-54, 127, -127, 18}; vecs[4].out1 = '{36, 0, -18, 91};
    vecs[5].in0 = '{1000, -1000, 0, 0};   vecs[5].in1 = '{0, -32768, 32767, -1};
    vecs[5].expMax = 32768;
    vecs[5].out0 = '{4, -4, 0, 0};        vecs[5].out1 = '{0, -127, 127, 0};
  endtask

  task automatic driveBeat(input int idx, input int b);
    for (int i = 0; i < 4; i++) begin
      data_in[i] = (b == 0) ? 16'(vecs[idx].in0[i]) : 16'(vecs[idx].in1[i]);
    end
  endtask

  task automatic sendBeat(input int idx, input int b);
    int waitCnt;
    waitCnt = 0;
    driveBeat(idx, b);
    data_in_valid = 1'b1;
    while (!data_in_ready && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (waitCnt >= 20) compare("inReadyWait", int'(data_in_ready), 1);
    @(posedge clk); #1;
    data_in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    sendBeat(idx, 0);
    sendBeat(idx, 1);
  endtask

  task automatic checkBeat(input int idx, input int b);
    for (int i = 0; i < 4; i++) begin
      compare($sformatf("v%0d_b%0d_out%0d", idx, b, i), int'(data_out[i]),
              (b == 0) ? vecs[idx].out0[i] : vecs[idx].out1[i]);
    end
    compare($sformatf("v%0d_b%0d_max", idx, b), int'(max_num), vecs[idx].expMax);
    compare($sformatf("v%0d_b%0d_last", idx, b), int'(data_out_last), (b == 1) ? 1 : 0);
    compare($sformatf("v%0d_b%0d_valid", idx, b), int'(data_out_valid), 1);
    compare($sformatf("v%0d_b%0d_inReady", idx, b), int'(data_in_ready), 0);
  endtask

  task automatic checkOutput(input int idx);
    int waitCnt;
    waitCnt = 0;
    while (!data_out_valid && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    for (int b = 0; b < 2; b++) begin
      checkBeat(idx, b);
      @(posedge clk); #1;
    end
    compare($sformatf("v%0d_validDone", idx), int'(data_out_valid), 0);
    compare($sformatf("v%0d_readyDone", idx), int'(data_in_ready), 1);
  endtask

  initial begin
    int accIdx;
    int seqVec [4];
    int seqBeat [4];
    checks = 0;
    failures = 0;
    fillVectors();
    rst = 1'b1;
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) data_in[i] = '0;

    #1;
    compare("rstInReady", int'(data_in_ready), 0);
    compare("rstOutValid", int'(data_out_valid), 0);
    compare("rstLast", int'(data_out_last), 0);
    compare("rstMax", int'(max_num), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    compare("inReadyBeforeEdge", int'(data_in_ready), 0);
    @(posedge clk); #1;
    compare("inReadyAfterEdge", int'(data_in_ready), 1);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(v);
      compare($sformatf("v%0d_latency", v), int'(data_out_valid), 1);
      checkOutput(v);
    end

    // Downstream stall with input offered: outputs hold and nothing is accepted.
    data_out_ready = 1'b0;
    applyStimulus(0);
    for (int k = 0; k < 5; k++) begin
      data_in_valid = 1'b1;
      for (int i = 0; i < 4; i++) data_in[i] = 16'(99 + i);
      @(posedge clk); #1;
      compare($sformatf("hold%0d_out0", k), int'(data_out[0]), 64);
      compare($sformatf("hold%0d_out1", k), int'(data_out[1]), -32);
      compare($sformatf("hold%0d_max", k), int'(max_num), 200);
      compare($sformatf("hold%0d_last", k), int'(data_out_last), 0);
      compare($sformatf("hold%0d_valid", k), int'(data_out_valid), 1);
      compare($sformatf("hold%0d_inReady", k), int'(data_in_ready), 0);
    end
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    checkOutput(0);

    // Reset after the first output handshake of a large-max block.
    applyStimulus(2);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    compare("midEmitRstValid", int'(data_out_valid), 0);
    compare("midEmitRstInReady", int'(data_in_ready), 0);
    compare("midEmitRstMax", int'(max_num), 0);
    compare("midEmitRstLast", int'(data_out_last), 0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    compare("midEmitRstReadyBack", int'(data_in_ready), 1);
    applyStimulus(3);
    checkOutput(3);

    // Reset in the middle of collecting a block.
    sendBeat(2, 0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    compare("midCollectRstReady", int'(data_in_ready), 1);
    applyStimulus(3);
    checkOutput(3);

    // Back-to-back blocks with both handshakes always offered.
    seqVec  = '{5, 5, 4, 4};
    seqBeat = '{0, 1, 0, 1};
    accIdx = 0;
    data_in_valid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      compare($sformatf("b2b%0d_inReady", t), int'(data_in_ready), (t % 4 < 2) ? 1 : 0);
      compare($sformatf("b2b%0d_valid", t), int'(data_out_valid), (t % 4 >= 2) ? 1 : 0);
      if (t % 4 >= 2) checkBeat((t < 4) ? 5 : 4, t % 2);
      if (data_in_ready && accIdx < 4) begin
        driveBeat(seqVec[accIdx], seqBeat[accIdx]);
        accIdx++;
      end
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
    compare("b2bAccepted", accIdx, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
